maze_direction_flag: RTL and testbench



---
 rtl/pacman_maze_pkg.sv | 56 +++++
 rtl/maze_segment_probe.sv | 39 +++
 rtl/maze_direction_flag.sv | 82 ++++++++
 tb/tb_maze_direction_flag.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pacman_maze_pkg.sv
// Shared maze constants: playfield size, wall rectangles, direction codes.
// Also the first-blocked run-length helper used by the look-ahead block.
package pacman_maze_pkg;

  localparam int FIELD_W   = 320;
  localparam int FIELD_H   = 240;
  localparam int SPRITE    = 16;
  localparam int MAX_LOOK  = 7;
  localparam int NUM_WALLS = 4;
  localparam int COORD_W   = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x0;
    coord_t x1;
    coord_t y0;
    coord_t y1;
  } rect_t;

  localparam coord_t C_ZERO = '0;
  localparam coord_t X_MAX  = coord_t'(FIELD_W - 1);
  localparam coord_t Y_MAX  = coord_t'(FIELD_H - 1);
  localparam coord_t SPAN   = coord_t'(SPRITE - 1);

  localparam rect_t WALLS [NUM_WALLS] = '{
    '{x0: 11'sd40,  x1: 11'sd279, y0: 11'sd60,  y1: 11'sd75},
    '{x0: 11'sd40,  x1: 11'sd55,  y0: 11'sd100, y1: 11'sd179},
    '{x0: 11'sd264, x1: 11'sd279, y0: 11'sd100, y1: 11'sd179},
    '{x0: 11'sd100, x1: 11'sd219, y0: 11'sd150, y1: 11'sd165}
  };

  // Probe orientation: a column probe has a fixed x and spans rows.
  localparam logic AXIS_COL = 1'b0;
  localparam logic AXIS_ROW = 1'b1;

  localparam logic [3:0] L = 4'b1000;
  localparam logic [3:0] U = 4'b0100;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] D = 4'b0001;

  function automatic logic [2:0] run_length(
    input logic [MAX_LOOK-1:0] free
  );
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_LOOK; i++) begin
      run = run & free[i];
      if (run) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/maze_segment_probe.sv
// One look-ahead segment: free when on-field and touching no wall.
// Purely combinational; the top registers the resulting counts.
module maze_segment_probe
  import pacman_maze_pkg::*;
(
  input  logic   axis,
  input  coord_t fixed,
  input  coord_t span_lo,
  input  coord_t span_hi,
  output logic   free
);

  logic in_field;
  logic hit;

  always_comb begin
    in_field = 1'b0;
    hit      = 1'b0;
    unique case (1'b1)
      (axis == AXIS_ROW):
        in_field = (fixed >= C_ZERO) && (fixed <= Y_MAX);
      default:
        in_field = (fixed >= C_ZERO) && (fixed <= X_MAX);
    endcase
    for (int w = 0; w < NUM_WALLS; w++) begin
      if (axis == AXIS_ROW) begin
        if (fixed >= WALLS[w].y0 && fixed <= WALLS[w].y1 &&
            span_lo <= WALLS[w].x1 && span_hi >= WALLS[w].x0)
          hit = 1'b1;
      end else begin
        if (fixed >= WALLS[w].x0 && fixed <= WALLS[w].x1 &&
            span_lo <= WALLS[w].y1 && span_hi >= WALLS[w].y0)
          hit = 1'b1;
      end
    end
    free = in_field & ~hit;
  end

endmodule

// File: rtl/maze_direction_flag.sv
// Per-direction free-pixel look-ahead for a 16x16 sprite in the maze.
// 28 parallel probes feed four first-blocked counters and output regs.
module maze_direction_flag
  import pacman_maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] x,
  input  logic [8:0] y,
  output logic [2:0] flag_L,
  output logic [2:0] flag_U,
  output logic [2:0] flag_R,
  output logic [2:0] flag_D
);

  coord_t sx;
  coord_t sy;
  coord_t sx_end;
  coord_t sy_end;

  logic [MAX_LOOK-1:0] free_l;
  logic [MAX_LOOK-1:0] free_u;
  logic [MAX_LOOK-1:0] free_r;
  logic [MAX_LOOK-1:0] free_d;

  // Widen before any add/subtract so off-field probes never wrap.
  assign sx     = $signed({2'b00, x});
  assign sy     = $signed({2'b00, y});
  assign sx_end = sx + SPAN;
  assign sy_end = sy + SPAN;

  for (genvar k = 1; k <= MAX_LOOK; k++) begin : g_k
    localparam coord_t KC = coord_t'(k);

    maze_segment_probe u_l (
      .axis    (AXIS_COL),
      .fixed   (sx - KC),
      .span_lo (sy),
      .span_hi (sy_end),
      .free    (free_l[k-1])
    );

    maze_segment_probe u_u (
      .axis    (AXIS_ROW),
      .fixed   (sy - KC),
      .span_lo (sx),
      .span_hi (sx_end),
      .free    (free_u[k-1])
    );

    maze_segment_probe u_r (
      .axis    (AXIS_COL),
      .fixed   (sx_end + KC),
      .span_lo (sy),
      .span_hi (sy_end),
      .free    (free_r[k-1])
    );

    maze_segment_probe u_d (
      .axis    (AXIS_ROW),
      .fixed   (sy_end + KC),
      .span_lo (sx),
      .span_hi (sx_end),
      .free    (free_d[k-1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_L <= '0;
      flag_U <= '0;
      flag_R <= '0;
      flag_D <= '0;
    end else begin
      flag_L <= run_length(free_l);
      flag_U <= run_length(free_u);
      flag_R <= run_length(free_r);
      flag_D <= run_length(free_d);
    end
  end

endmodule

// File: tb/tb_maze_direction_flag.sv
// Directed bench for maze_direction_flag with hand-derived flag values.
module tb_maze_direction_flag;

  logic       clk;
  logic       rst_n;
  logic [8:0] x;
  logic [8:0] y;
  logic [2:0] flag_L;
  logic [2:0] flag_U;
  logic [2:0] flag_R;
  logic [2:0] flag_D;

  int tests;
  int fails;

  maze_direction_flag dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x),
    .y      (y),
    .flag_L (flag_L),
    .flag_U (flag_U),
    .flag_R (flag_R),
    .flag_D (flag_D)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk1(input string tag, input logic [2:0] got,
                      input logic [2:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] el,
                     input logic [2:0] eu, input logic [2:0] er,
                     input logic [2:0] ed);
    chk1({tag, ".L"}, flag_L, el);
    chk1({tag, ".U"}, flag_U, eu);
    chk1({tag, ".R"}, flag_R, er);
    chk1({tag, ".D"}, flag_D, ed);
  endtask

  task automatic apply(input int nx, input int ny);
    @(negedge clk);
    x = 9'(nx);
    y = 9'(ny);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    x     = 9'd20;
    y     = 9'd200;
    #1;
    chk("rst_t0", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel", 7, 7, 7, 7);

    apply(0, 0);
    chk("corner", 0, 0, 7, 7);
    apply(304, 224);
    chk("br_edge", 7, 7, 0, 0);
    apply(100, 41);
    chk("w0_above", 7, 7, 7, 3);
    apply(56, 120);
    chk("w1_adj", 0, 7, 7, 7);
    apply(58, 120);
    chk("w1_gap2", 2, 7, 7, 7);
    apply(150, 172);
    chk("w3_below", 7, 6, 7, 7);
    apply(245, 120);
    chk("w2_left", 7, 7, 3, 7);
    apply(300, 200);
    chk("start_b", 7, 7, 4, 7);
    apply(100, 30);
    chk("start_c", 7, 7, 7, 7);

    // Latency: new x becomes visible only after the next rising edge.
    apply(56, 120);
    chk1("lat_pre", flag_L, 0);
    @(negedge clk);
    x = 9'd58;
    #1;
    chk1("lat_hold", flag_L, 0);
    @(posedge clk);
    #1;
    chk1("lat_post", flag_L, 2);

    // Asynchronous reset pulse between clock edges.
    #4;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_async_hold", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_async_rel", 2, 7, 7, 7);

    apply(20, 200);
    chk("start_a", 7, 7, 7, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
